// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Data requests win over fetch; address and store lanes are held in registers for the whole transaction.
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 if_req,
  input  logic [XLEN-1:0]      if_addr,
  output logic                 if_ack,
  output logic [XLEN-1:0]      if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [XLEN-1:0]      d_addr,
  input  logic [0:3][7:0]      d_wdata,
  output logic                 d_ack,
  output logic [0:3][7:0]      d_rdata,
  input  logic                 halted,
  output logic [XLEN-1:0]      mem_addr,
  output logic                 mem_write_en,
  output logic [0:3][7:0]      mem_data_in,
  input  logic [0:3][7:0]      mem_data_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t          state;
  logic [2:0]      cnt;
  logic [XLEN-1:0] addr_q;
  logic [0:3][7:0] wdata_q;
  logic [XLEN-1:0] if_rdata_q;
  logic [0:3][7:0] d_rdata_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!halted) begin
            if (d_req) begin
              addr_q <= d_addr;
              if (d_we) begin
                wdata_q <= d_wdata;
                state   <= D_WR;
              end else begin
                cnt   <= LAT_INIT;
                state <= D_RD;
              end
            end else if (if_req) begin
              addr_q <= if_addr;
              cnt    <= LAT_INIT;
              state  <= IF_RD;
            end
          end
        end
        IF_RD: begin
          if (cnt == 3'd0) begin
            if_rdata_q <= XLEN'(mem_data_out);
            state      <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        D_RD: begin
          if (cnt == 3'd0) begin
            d_rdata_q <= mem_data_out;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        D_WR:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Acks decode straight from state so read data can pass through in the ack cycle.
  always_comb begin
    if_ack       = (state == IF_RD) && (cnt == 3'd0);
    d_ack        = ((state == D_RD) && (cnt == 3'd0)) || (state == D_WR);
    mem_write_en = (state == D_WR);
    busy         = (state != IDLE);
    mem_addr     = addr_q;
    mem_data_in  = wdata_q;
    if_rdata     = if_ack ? XLEN'(mem_data_out) : if_rdata_q;
    d_rdata      = (state == D_RD && cnt == 3'd0) ? mem_data_out : d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3
// Two instances share clock, reset and a few static inputs; each has its own requests and memory lanes.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic        d_we;
  logic [31:0] if_addr;
  logic [31:0] d_wdata;

  logic        if_req1, d_req1;
  logic [31:0] d_addr1, mem_out1;
  logic        if_ack1, d_ack1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_din1;

  logic        if_req3, d_req3;
  logic [31:0] d_addr3, mem_out3;
  logic        if_ack3, d_ack3, mem_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_din3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .XLEN(32)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req1), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we), .d_addr(d_addr1), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .halted(halted),
    .mem_addr(mem_addr1), .mem_write_en(mem_we1), .mem_data_in(mem_din1),
    .mem_data_out(mem_out1), .busy(busy1)
  );

  mem_arbiter #(.MEM_LAT(3), .XLEN(32)) dut3 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req3), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr3), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .halted(halted),
    .mem_addr(mem_addr3), .mem_write_en(mem_we3), .mem_data_in(mem_din3),
    .mem_data_out(mem_out3), .busy(busy3)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; halted = 1'b0; d_we = 1'b0; if_addr = '0; d_wdata = '0;
    if_req1 = 1'b0; d_req1 = 1'b0; d_addr1 = '0; mem_out1 = '0;
    if_req3 = 1'b0; d_req3 = 1'b0; d_addr3 = '0; mem_out3 = '0;
    step(); step();
    chk1 ("rst_busy", busy1, 1'b0);
    chk1 ("rst_if_ack", if_ack1, 1'b0);
    chk1 ("rst_d_ack", d_ack1, 1'b0);
    chk1 ("rst_we", mem_we1, 1'b0);
    chk32("rst_mem_addr", mem_addr1, 32'h0);
    chk32("rst_mem_din", mem_din1, 32'h0);
    chk32("rst_if_rdata", if_rdata1, 32'h0);
    chk32("rst_d_rdata", d_rdata1, 32'h0);
    rst_b = 1'b1;
    step();

    // Fetch at latency 1
    mem_out1 = 32'hAABBCCDD; if_addr = 32'h40; if_req1 = 1'b1;
    chk1 ("if_idle_busy", busy1, 1'b0);
    step();
    chk1 ("if_ack", if_ack1, 1'b1);
    chk32("if_rdata", if_rdata1, 32'hAABBCCDD);
    chk32("if_mem_addr", mem_addr1, 32'h40);
    chk1 ("if_we", mem_we1, 1'b0);
    chk1 ("if_busy", busy1, 1'b1);
    chk1 ("if_no_d_ack", d_ack1, 1'b0);
    if_req1 = 1'b0;
    step();
    mem_out1 = 32'h0;
    #1;
    chk1 ("if_ack_drop", if_ack1, 1'b0);
    chk32("if_rdata_hold", if_rdata1, 32'hAABBCCDD);
    chk1 ("if_back_idle", busy1, 1'b0);

    // Store
    d_req1 = 1'b1; d_we = 1'b1; d_addr1 = 32'h100; d_wdata = 32'h11223344;
    step();
    d_wdata = 32'hDEADBEEF;
    #1;
    chk1 ("st_we", mem_we1, 1'b1);
    chk1 ("st_ack", d_ack1, 1'b1);
    chk32("st_addr", mem_addr1, 32'h100);
    chk32("st_lanes", mem_din1, 32'h11223344);
    d_req1 = 1'b0; d_we = 1'b0;
    step();
    chk1 ("st_we_one", mem_we1, 1'b0);
    chk1 ("st_ack_one", d_ack1, 1'b0);
    chk1 ("st_idle", busy1, 1'b0);

    // Simultaneous fetch and load: data first
    mem_out1 = 32'h55667788; if_addr = 32'h40; if_req1 = 1'b1;
    d_req1 = 1'b1; d_addr1 = 32'h200;
    step();
    chk1 ("both_d_ack", d_ack1, 1'b1);
    chk1 ("both_no_if_ack", if_ack1, 1'b0);
    chk32("both_d_rdata", d_rdata1, 32'h55667788);
    chk32("both_d_addr", mem_addr1, 32'h200);
    d_req1 = 1'b0;
    step();
    chk1 ("both_gap_busy", busy1, 1'b0);
    chk1 ("both_gap_if_ack", if_ack1, 1'b0);
    chk1 ("both_gap_d_ack", d_ack1, 1'b0);
    mem_out1 = 32'h99AABBCC;
    step();
    chk1 ("both_if_ack", if_ack1, 1'b1);
    chk1 ("both_if_no_d_ack", d_ack1, 1'b0);
    chk32("both_if_rdata", if_rdata1, 32'h99AABBCC);
    chk32("both_if_addr", mem_addr1, 32'h40);
    chk32("both_d_rdata_hold", d_rdata1, 32'h55667788);
    if_req1 = 1'b0;
    step();

    // Halted blocks grants
    halted = 1'b1; if_req1 = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1 ("halt_busy", busy1, 1'b0);
      chk1 ("halt_if_ack", if_ack1, 1'b0);
    end
    halted = 1'b0;
    step();
    chk1 ("unhalt_if_ack", if_ack1, 1'b1);
    chk32("unhalt_addr", mem_addr1, 32'h80);
    if_req1 = 1'b0;
    step();

    // Latency 3 load with address change after grant
    mem_out3 = 32'h01020304; d_req3 = 1'b1; d_addr3 = 32'h8;
    step();
    chk1 ("l3_busy", busy3, 1'b1);
    chk1 ("l3_ack_c1", d_ack3, 1'b0);
    chk32("l3_addr_c1", mem_addr3, 32'h8);
    d_addr3 = 32'hFFF0;
    step();
    chk1 ("l3_ack_c2", d_ack3, 1'b0);
    chk32("l3_addr_c2", mem_addr3, 32'h8);
    step();
    chk1 ("l3_ack_c3", d_ack3, 1'b1);
    chk32("l3_rdata", d_rdata3, 32'h01020304);
    chk1 ("l3_no_if_ack", if_ack3, 1'b0);
    d_req3 = 1'b0;
    step();
    chk1 ("l3_ack_done", d_ack3, 1'b0);
    chk1 ("l3_idle", busy3, 1'b0);

    // Reset in the second cycle of a latency 3 read
    mem_out3 = 32'h0A0B0C0D; d_req3 = 1'b1; d_addr3 = 32'h20;
    step();
    step();
    rst_b = 1'b0;
    #1;
    chk1 ("mid_rst_busy", busy3, 1'b0);
    chk1 ("mid_rst_ack", d_ack3, 1'b0);
    chk1 ("mid_rst_we", mem_we3, 1'b0);
    chk32("mid_rst_addr", mem_addr3, 32'h0);
    chk32("mid_rst_d_rdata", d_rdata3, 32'h0);
    chk32("mid_rst_if_rdata1", if_rdata1, 32'h0);
    step();
    chk1 ("rst_hold_ack", d_ack3, 1'b0);
    rst_b = 1'b1;
    step();
    chk1 ("rearb_busy", busy3, 1'b1);
    chk32("rearb_addr", mem_addr3, 32'h20);
    chk1 ("rearb_ack_c1", d_ack3, 1'b0);
    step();
    chk1 ("rearb_ack_c2", d_ack3, 1'b0);
    step();
    chk1 ("rearb_ack_c3", d_ack3, 1'b1);
    chk32("rearb_rdata", d_rdata3, 32'h0A0B0C0D);
    d_req3 = 1'b0;
    step();
    chk1 ("rearb_idle", busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles (1..7) from the address being driven to mem_data_out being valid.
REQ-002 Parameter XLEN, default 32: address and word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request; held until if_ack.
REQ-006 if_addr  input  XLEN  fetch byte address; stable while if_req is high.
REQ-007 if_ack  output  1  one-cycle pulse; if_rdata valid in the same cycle.
REQ-008 if_rdata  output  XLEN  fetched word, {lane0,lane1,lane2,lane3}.
REQ-009 d_req  input  1  data-access request; held until d_ack.
REQ-010 d_we  input  1  data-access type: 1=store, 0=load.
REQ-011 d_addr  input  XLEN  data byte address.
REQ-012 d_wdata  input  8x[0:3]  store byte lanes.
REQ-013 d_ack  output  1  one-cycle completion pulse.
REQ-014 d_rdata  output  8x[0:3]  load byte lanes; valid with d_ack.
REQ-015 halted  input  1  core halted; blocks new grants.
REQ-016 mem_addr  output  XLEN  shared memory address.
REQ-017 mem_write_en  output  1  shared memory write strobe.
REQ-018 mem_data_in  output  8x[0:3]  write lanes to memory.
REQ-019 mem_data_out  input  8x[0:3]  read lanes from memory.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, IF_RD, D_RD, D_WR.
REQ-022 IDLE, halted=0, d_req=1: go to D_WR if d_we=1, otherwise D_RD; data has priority over fetch.
REQ-023 IDLE, halted=0, d_req=0, if_req=1: go to IF_RD.
REQ-024 IDLE with halted=1: stay in IDLE and issue no grant; a transaction already in flight completes normally.
REQ-025 Grant latches the address, the type and (for stores) d_wdata into internal registers; mem_addr and mem_data_in are driven from these registers only, never from the live inputs.
REQ-026 Latency counter loads MEM_LAT-1 on entry to IF_RD or D_RD and decrements each cycle.
REQ-027 IF_RD/D_RD completion: in the cycle the counter is 0, pulse if_ack/d_ack, sample mem_data_out combinationally into if_rdata/d_rdata, and return to IDLE.
REQ-028 D_WR: mem_write_en=1 for exactly one cycle, d_ack pulses in that same cycle, then return to IDLE.
REQ-029 mem_write_en SHALL be 1 only in D_WR.
REQ-030 A request seen in IDLE on the cycle after an ack is granted then, giving a minimum of one idle cycle between transactions.
REQ-031 if_req and d_req asserted together: data is served first; fetch is granted on the next IDLE cycle if if_req is still high.
REQ-032 A request dropped before its ack is a protocol error; the transaction still completes, and the resulting ack is ignored by the requester.
REQ-033 if_rdata/d_rdata SHALL hold their last acked value between acks.
REQ-034 if_ack and d_ack SHALL never be high in the same cycle.
REQ-035 Address handling: the arbiter passes addresses unchanged and performs no alignment check.

Reset
REQ-036 rst_b=0 immediately forces IDLE, counter=0, if_ack=0, d_ack=0, mem_write_en=0, busy=0, mem_addr=0, mem_data_in=0, if_rdata=0, d_rdata=0.
REQ-037 Reset mid-transaction aborts it with no ack; after release, pending requests are re-arbitrated from IDLE.

Verification
REQ-038 MEM_LAT=1, if_req with if_addr=0x40 and memory lanes AA,BB,CC,DD: if_ack one cycle after grant, if_rdata=0xAABBCCDD, mem_write_en stays 0.
REQ-039 d_req, d_we=1, d_addr=0x100, lanes 11,22,33,44: one cycle of mem_write_en with mem_addr=0x100 and the lanes on mem_data_in; d_ack in the same cycle.
REQ-040 if_req and d_req (load, 0x200) raised in the same cycle: d_ack first, then if_ack; never both together; one IDLE cycle between them.
REQ-041 MEM_LAT=3, load at 0x8: d_ack exactly 3 cycles after the grant cycle; changing d_addr after the grant does not alter mem_addr.
REQ-042 rst_b pulsed low in the 2nd cycle of a MEM_LAT=3 read: no ack, all outputs 0, and after release the still-held request completes from IDLE.
REQ-043 halted=1 with if_req high: no grant for 10 cycles and busy=0.
